// File: rtl/mac_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the matrix-vector MAC sequencer.
// sat_add is the reference saturating accumulate step used by MAC models.
package mac_pkg;

  localparam int DW   = 14;
  localparam int AccW = 28;

  localparam logic signed [AccW-1:0] ACC_MAX = {1'b0, {(AccW-1){1'b1}}};
  localparam logic signed [AccW-1:0] ACC_MIN = {1'b1, {(AccW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // One accumulate step: a + b, clamped to the signed AccW range on overflow.
  function automatic logic signed [AccW-1:0] sat_add(input logic signed [AccW-1:0] a,
                                                     input logic signed [AccW-1:0] b);
    logic [AccW:0] sum;
    sum = {a[AccW-1], a} + {b[AccW-1], b};
    if (sum[AccW] != sum[AccW-1]) begin
      sat_add = sum[AccW] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_add = sum[AccW-1:0];
    end
  endfunction

endpackage

// File: rtl/mac_mvm_cnt.sv
// Generic synchronous up-counter: clear has priority, wraps after LIMIT-1, flags the last value.
module mac_mvm_cnt #(
  parameter int LIMIT = 4,
  parameter int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LastVal = W'(LIMIT - 1);

  logic [W-1:0] count_r;

  // Count register with wrap at the last value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_r <= {W{1'b0}};
    end else if (inc) begin
      if (count_r == LastVal) begin
        count_r <= {W{1'b0}};
      end else begin
        count_r <= count_r + W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign last  = (count_r == LastVal);

endmodule

// File: rtl/mac_mvm_ctrl.sv
// Sequencer for y = W*x on one external pipelined saturating MAC.
// Row end is found by counting MAC valid_out pulses, never by assuming a fixed MAC latency.
module mac_mvm_ctrl
  import mac_pkg::*;
#(
  parameter int M      = 3,
  parameter int N      = 4,
  parameter int WAddrW = (M * N > 1) ? $clog2(M * N) : 1,
  parameter int XAddrW = (N > 1) ? $clog2(N) : 1,
  parameter int YAddrW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   done,
  output logic [WAddrW-1:0]      addr_w,
  output logic [XAddrW-1:0]      addr_x,
  output logic                   rd_en,
  input  logic signed [DW-1:0]   data_w,
  input  logic signed [DW-1:0]   data_x,
  output logic [YAddrW-1:0]      addr_y,
  output logic                   wr_en_y,
  output logic signed [AccW-1:0] data_y,
  output logic signed [DW-1:0]   mac_a,
  output logic signed [DW-1:0]   mac_b,
  output logic                   mac_valid_in,
  output logic                   mac_reset,
  input  logic signed [AccW-1:0] mac_f,
  input  logic                   mac_valid_out
);

  state_t state_r;
  state_t state_nxt_s;

  logic s_ready_r;
  logic rd_en_r;
  logic wr_en_y_r;
  logic done_r;
  logic clear_r;
  logic mac_valid_in_r;

  logic [WAddrW-1:0]      addr_w_r;
  logic signed [AccW-1:0] data_y_r;

  logic [XAddrW-1:0] col_s;
  logic              col_last_s;
  logic [YAddrW-1:0] row_s;
  logic              row_last_s;
  logic [XAddrW-1:0] rcv_unused_s;
  logic              rcv_last_s;

  logic start_s;
  logic streaming_s;
  logic counting_s;
  logic row_done_s;

  assign start_s     = (state_r == IDLE) && s_valid;
  assign streaming_s = (state_r == STREAM);
  // Pulses arriving while STREAM is still issuing belong to the current row as well.
  assign counting_s  = mac_valid_out && ((state_r == STREAM) || (state_r == DRAIN));
  assign row_done_s  = mac_valid_out && (state_r == DRAIN) && rcv_last_s;

  mac_mvm_cnt #(.LIMIT(N), .W(XAddrW)) u_col (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_r),
    .inc   (streaming_s),
    .count (col_s),
    .last  (col_last_s)
  );

  mac_mvm_cnt #(.LIMIT(M), .W(YAddrW)) u_row (
    .clk   (clk),
    .reset (reset),
    .clr   (start_s),
    .inc   (state_r == WRITE),
    .count (row_s),
    .last  (row_last_s)
  );

  mac_mvm_cnt #(.LIMIT(N), .W(XAddrW)) u_rcv (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_r),
    .inc   (counting_s),
    .count (rcv_unused_s),
    .last  (rcv_last_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (s_valid) state_nxt_s = CLEAR;
        else         state_nxt_s = IDLE;
      end
      CLEAR:  state_nxt_s = STREAM;
      STREAM: begin
        if (col_last_s) state_nxt_s = DRAIN;
        else            state_nxt_s = STREAM;
      end
      DRAIN: begin
        if (row_done_s) state_nxt_s = WRITE;
        else            state_nxt_s = DRAIN;
      end
      WRITE: begin
        if (row_last_s) state_nxt_s = DONE;
        else            state_nxt_s = CLEAR;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; strobes are decoded from the next state so they are flops aligned with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      s_ready_r      <= 1'b1;
      rd_en_r        <= 1'b0;
      wr_en_y_r      <= 1'b0;
      done_r         <= 1'b0;
      clear_r        <= 1'b0;
      mac_valid_in_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      s_ready_r      <= (state_nxt_s == IDLE);
      rd_en_r        <= (state_nxt_s == STREAM);
      wr_en_y_r      <= (state_nxt_s == WRITE);
      done_r         <= (state_nxt_s == DONE);
      clear_r        <= (state_nxt_s == CLEAR);
      mac_valid_in_r <= rd_en_r;
    end
  end

  // W address walks row-major over the whole run, one step per read; no row*N product needed.
  always_ff @(posedge clk) begin
    if (reset || start_s) begin
      addr_w_r <= {WAddrW{1'b0}};
    end else if (streaming_s) begin
      addr_w_r <= addr_w_r + WAddrW'(1);
    end else begin
      addr_w_r <= addr_w_r;
    end
  end

  // Capture the accumulator at the row's final valid_out pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_y_r <= {AccW{1'b0}};
    end else if (row_done_s) begin
      data_y_r <= mac_f;
    end else begin
      data_y_r <= data_y_r;
    end
  end

  assign s_ready      = s_ready_r;
  assign done         = done_r;
  assign rd_en        = rd_en_r;
  assign addr_w       = addr_w_r;
  assign addr_x       = col_s;
  assign addr_y       = row_s;
  assign wr_en_y      = wr_en_y_r;
  assign data_y       = data_y_r;
  assign mac_a        = data_w;
  assign mac_b        = data_x;
  assign mac_valid_in = mac_valid_in_r;
  assign mac_reset    = reset | clear_r;

endmodule

// File: tb/tb_mac_mvm_ctrl.sv
// Directed bench: behavioural W/x memories and a 2-stage saturating MAC around two controllers
// (3x4 and 1x1); y writes are checked against a queue of expected results.
module tb_mac_mvm_ctrl;
  import mac_pkg::*;

  localparam int M   = 3;
  localparam int N   = 4;
  localparam int WAW = 4;
  localparam int XAW = 2;
  localparam int YAW = 2;

  typedef struct {
    int a;
    int d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready, done, rd_en, wr_en_y, mac_valid_in, mac_reset, mac_valid_out;
  logic [WAW-1:0] addr_w;
  logic [XAW-1:0] addr_x;
  logic [YAW-1:0] addr_y;
  logic signed [DW-1:0] data_w, data_x, mac_a, mac_b;
  logic signed [AccW-1:0] data_y, mac_f;

  logic s_valid1 = 1'b0;
  logic s_ready1, done1, rd_en1, wr_en_y1, mac_valid_in1, mac_reset1, mac_valid_out1;
  logic [0:0] addr_w1, addr_x1, addr_y1;
  logic signed [DW-1:0] data_w1, data_x1, mac_a1, mac_b1;
  logic signed [AccW-1:0] data_y1, mac_f1;

  mac_mvm_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .done(done),
    .addr_w(addr_w), .addr_x(addr_x), .rd_en(rd_en), .data_w(data_w), .data_x(data_x),
    .addr_y(addr_y), .wr_en_y(wr_en_y), .data_y(data_y), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid_in(mac_valid_in), .mac_reset(mac_reset), .mac_f(mac_f),
    .mac_valid_out(mac_valid_out)
  );

  mac_mvm_ctrl #(.M(1), .N(1)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid1), .s_ready(s_ready1), .done(done1),
    .addr_w(addr_w1), .addr_x(addr_x1), .rd_en(rd_en1), .data_w(data_w1), .data_x(data_x1),
    .addr_y(addr_y1), .wr_en_y(wr_en_y1), .data_y(data_y1), .mac_a(mac_a1), .mac_b(mac_b1),
    .mac_valid_in(mac_valid_in1), .mac_reset(mac_reset1), .mac_f(mac_f1),
    .mac_valid_out(mac_valid_out1)
  );

  // Sync-read memories
  logic signed [DW-1:0] wmem [M*N];
  logic signed [DW-1:0] xmem [N];
  logic signed [DW-1:0] w1mem [2];
  logic signed [DW-1:0] x1mem [2];

  always @(posedge clk) begin
    if (rd_en) begin
      data_w <= wmem[addr_w];
      data_x <= xmem[addr_x];
    end
    if (rd_en1) begin
      data_w1 <= w1mem[addr_w1];
      data_x1 <= x1mem[addr_x1];
    end
  end

  // Pipelined MAC: product stage, then saturating accumulate with valid_out
  logic p_v, vout, p_v1, vout1;
  logic signed [AccW-1:0] prod, acc, prod1, acc1;

  always @(posedge clk) begin
    if (mac_reset) begin
      p_v <= 1'b0; vout <= 1'b0; prod <= '0; acc <= '0;
    end else begin
      p_v  <= mac_valid_in;
      prod <= AccW'(mac_a) * AccW'(mac_b);
      vout <= p_v;
      if (p_v) acc <= sat_add(acc, prod);
    end
    if (mac_reset1) begin
      p_v1 <= 1'b0; vout1 <= 1'b0; prod1 <= '0; acc1 <= '0;
    end else begin
      p_v1  <= mac_valid_in1;
      prod1 <= AccW'(mac_a1) * AccW'(mac_b1);
      vout1 <= p_v1;
      if (p_v1) acc1 <= sat_add(acc1, prod1);
    end
  end

  assign mac_f          = acc;
  assign mac_valid_out  = vout;
  assign mac_f1         = acc1;
  assign mac_valid_out1 = vout1;

  int cyc = 0;
  int n_acc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_valid && s_ready) n_acc <= n_acc + 1;
  end

  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0, n_done = 0, n_rd = 0, last_wr = 0, last_done = 0;
  int wr0, done0, rd0, acc0;
  int n_rd1 = 0, n_wr1 = 0, n_done1 = 0, wr1_cyc = 0, done1_cyc = 0;
  exp_t sb[$];
  int sb1[$];

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int a, input int d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and score any y write / done / read on DUT 0
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rd_en) n_rd++;
    if (wr_en_y) begin
      n_wr++;
      last_wr = cyc;
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("y_addr", addr_y, e.a);
        chk("y_data", data_y, e.d);
      end
    end
    if (done) begin
      n_done++;
      last_done = cyc;
    end
  endtask

  task automatic start0();
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) tick();
    chk("done_seen", n_done - d0, 1);
  endtask

  task automatic load_t1();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        wmem[r*N+c] = (r == 2) ? DW'(-(c + 1)) : DW'(r * 4 + c + 1);
    for (int c = 0; c < N; c++) xmem[c] = DW'(c + 5);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en_y", wr_en_y, 0);
    chk("rst_done", done, 0);
    chk("rst_mac_reset", mac_reset, 1);
    chk("rst_s_ready1", s_ready1, 1);
    reset = 1'b0;
    tick();
    chk("idle_mac_reset", mac_reset, 0);

    // Test 1: basic 3x4 product
    load_t1();
    push(0, 70); push(1, 174); push(2, -70);
    wr0 = n_wr; rd0 = n_rd;
    start0();
    chk("t1_busy_s_ready", s_ready, 0);
    wait_done(300);
    chk("t1_writes", n_wr - wr0, 3);
    chk("t1_reads", n_rd - rd0, 12);
    chk("t1_done_after_write", last_done - last_wr, 1);
    tick();
    chk("t1_done_width", done, 0);
    chk("t1_s_ready_back", s_ready, 1);
    chk("t1_sb_empty", sb.size(), 0);

    // Test 2: positive and negative saturation, plus an alternating-sign row
    for (int c = 0; c < N; c++) begin
      wmem[c]       = DW'(8191);
      wmem[N+c]     = DW'(-8192);
      wmem[2*N+c]   = (c % 2 == 0) ? DW'(8191) : DW'(-8192);
      xmem[c]       = DW'(8191);
    end
    push(0, 134217727); push(1, -134217728); push(2, -16382);
    wr0 = n_wr;
    start0();
    wait_done(300);
    chk("t2_writes", n_wr - wr0, 3);

    // Test 3: accumulator cleared between rows
    for (int i = 0; i < M*N; i++) wmem[i] = (i < N) ? DW'(100) : DW'(0);
    for (int c = 0; c < N; c++) xmem[c] = DW'(100);
    push(0, 40000); push(1, 0); push(2, 0);
    wr0 = n_wr;
    tick();
    start0();
    wait_done(300);
    chk("t3_writes", n_wr - wr0, 3);

    // Test 4: reset two cycles into row-1 DRAIN
    load_t1();
    push(0, 70);
    wr0 = n_wr; done0 = n_done;
    tick();
    start0();
    for (int i = 0; i < 100 && n_wr == wr0; i++) tick();
    chk("t4_first_write", n_wr - wr0, 1);
    for (int i = 0; i < 50 && !rd_en; i++) tick();
    for (int i = 0; i < 50 && rd_en; i++) tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t4_mac_reset", mac_reset, 1);
    chk("t4_s_ready", s_ready, 1);
    chk("t4_rd_en", rd_en, 0);
    reset = 1'b0;
    repeat (40) tick();
    chk("t4_no_more_writes", n_wr - wr0, 1);
    chk("t4_no_done", n_done - done0, 0);
    chk("t4_sb_empty", sb.size(), 0);
    push(0, 70); push(1, 174); push(2, -70);
    wr0 = n_wr;
    start0();
    wait_done(300);
    chk("t4_restart_writes", n_wr - wr0, 3);

    // Test 5: s_valid held high -> one run, then a back-to-back run right after done
    tick();
    push(0, 70); push(1, 174); push(2, -70);
    push(0, 70); push(1, 174); push(2, -70);
    wr0 = n_wr; acc0 = n_acc;
    s_valid = 1'b1;
    wait_done(300);
    chk("t5_s_ready_at_done", s_ready, 0);
    chk("t5_one_accept", n_acc - acc0, 1);
    tick();
    chk("t5_s_ready_after_done", s_ready, 1);
    tick();
    chk("t5_second_accept", n_acc - acc0, 2);
    s_valid = 1'b0;
    wait_done(300);
    chk("t5_writes", n_wr - wr0, 6);
    chk("t5_sb_empty", sb.size(), 0);

    // Test 6: M=N=1 controller
    w1mem[0] = DW'(-3); w1mem[1] = DW'(0);
    x1mem[0] = DW'(7);  x1mem[1] = DW'(0);
    sb1.push_back(-21);
    s_valid1 = 1'b1;
    tick();
    s_valid1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_en1) n_rd1++;
      if (wr_en_y1) begin
        n_wr1++;
        wr1_cyc = cyc;
        chk("t6_y_addr", addr_y1, 0);
        if (sb1.size() == 0) chk("t6_sb_underflow", sb1.size(), 1);
        else chk("t6_y_data", data_y1, sb1.pop_front());
      end
      if (done1) begin
        n_done1++;
        done1_cyc = cyc;
      end
    end
    chk("t6_rd_cycles", n_rd1, 1);
    chk("t6_writes", n_wr1, 1);
    chk("t6_dones", n_done1, 1);
    chk("t6_done_after_write", done1_cyc - wr1_cyc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
